// File: rtl/sseg_pkg.sv
// Shared constants for the multiplexed 7-segment score display:
// segment encodings, converter states and a width helper.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } b2b_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // segments g..a, active low
  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_mux_display_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with a
// one-deep pending slot for loads that arrive while busy.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int SW = 4 * DIGITS + 4;
  localparam int CW = clog2(BIN_W + 1);

  b2b_state_e       state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [SW-1:0]    bcd_q, bcd_d;
  logic [SW-1:0]    adj;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [BIN_W-1:0] pbin_q, pbin_d;
  logic             restart;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pbin_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pbin_q  <= pbin_d;
    end
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pbin_d  = pbin_q;
    done_o  = 1'b0;
    restart = pend_q || load_i;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          sr_d    = bin_i;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CW'(BIN_W - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        carry_d = carry_q | adj[SW-1];
        bcd_d   = {adj[SW-2:0], sr_q[BIN_W-1]};
        sr_d    = sr_q << 1;
        if (load_i) begin
          pend_d = 1'b1;
          pbin_d = bin_i;
        end
        if (cnt_q == '0) state_d = ST_DONE;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_DONE: begin
        // a superseded result is dropped so it never reaches the display
        if (restart) begin
          sr_d    = load_i ? bin_i : pbin_q;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CW'(BIN_W - 1);
          pend_d  = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign bcd_o  = bcd_q[4*DIGITS-1:0];
  assign ovf_o  = carry_q | (|bcd_q[SW-1 -: 4]);

endmodule

// File: rtl/sseg_mux_display.sv
// Multiplexed common-anode 7-segment score display with blanking,
// decimal points, overflow dashes and blink.
module sseg_mux_display
  import sseg_pkg::*;
#(
  parameter int CLK_FREQ = 65_000_000,
  parameter int SCAN_HZ  = 4000,
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int BLANK_LZ = 1,
  parameter int BLINK_HZ = 2
) (
  input  logic              clk65MHz,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin,
  input  logic              load,
  input  logic              blink_en,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        sseg_ca,
  output logic              sseg_dp,
  output logic [DIGITS-1:0] sseg_an
);

  localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_FREQ / BLINK_HZ;
  localparam int SCW = clog2(SCAN_DIV);
  localparam int BLW = clog2(BLINK_DIV);
  localparam int DW  = clog2(DIGITS);

  logic                b2b_done;
  logic                b2b_ovf;
  logic [4*DIGITS-1:0] b2b_bcd;

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [SCW-1:0]      scan_q, scan_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [BLW-1:0]      blk_q, blk_d;
  logic                phase_q, phase_d;
  logic                tick;

  logic [DIGITS-1:0]   lz;
  logic                lz_acc;
  logic [3:0]          nib;
  logic                blank, off;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          ca_d;
  logic                dp_d;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_b2b (
    .clk_i  (clk65MHz),
    .rst_ni (rst_n),
    .load_i (load),
    .bin_i  (bin),
    .busy_o (busy),
    .done_o (b2b_done),
    .bcd_o  (b2b_bcd),
    .ovf_o  (b2b_ovf)
  );

  assign disp_d = b2b_done ? b2b_bcd : disp_q;
  assign ovf_d  = b2b_done ? b2b_ovf : ovf_q;

  assign tick   = (scan_q == '0);
  assign scan_d = tick ? SCW'(SCAN_DIV - 1) : scan_q - 1'b1;

  always_comb begin
    dig_d = dig_q;
    if (tick)
      dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
  end

  always_comb begin
    blk_d   = blk_q + 1'b1;
    phase_d = phase_q;
    if (blk_q == BLW'(BLINK_DIV - 1)) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // lz[k]: nibbles k..DIGITS-1 of the next display value are all zero
  always_comb begin
    lz     = '0;
    lz_acc = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_acc = lz_acc & (disp_d[4*k +: 4] == 4'd0);
      lz[k]  = lz_acc;
    end
  end

  // outputs come from next-state values so a digit never tears
  always_comb begin
    nib   = disp_d[4*dig_d +: 4];
    blank = (BLANK_LZ != 0) && (dig_d != '0)
            && !ovf_d && lz[dig_d];
    off   = blank || (blink_en && !phase_d);
    an_d  = off ? '1 : ~(DIGITS'(1) << dig_d);
    dp_d  = off | ~dp_mask[dig_d];
    ca_d  = SEG_BLANK;
    unique case (1'b1)
      off:            ca_d = SEG_BLANK;
      !off && ovf_d:  ca_d = SEG_DASH;
      !off && !ovf_d: ca_d = seg_encode(nib);
    endcase
  end

  always_ff @(posedge clk65MHz) begin
    if (!rst_n) begin
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      scan_q  <= '0;
      dig_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b1;
      sseg_an <= '1;
      sseg_ca <= SEG_BLANK;
      sseg_dp <= 1'b1;
    end else begin
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      sseg_an <= an_d;
      sseg_ca <= ca_d;
      sseg_dp <= dp_d;
    end
  end

  assign ovf = ovf_q;

endmodule
